prio_code_capture: RTL and testbench

- Downstream consumer of the 8-to-3 active-low priority encoder.
- Synchronises the encoder outputs (oY_L, oYex_L, oYs) into the system clock and debounces the active request.
- Emits exactly one code event per press/release cycle into a small FIFO.
- FIFO is drained by a valid/ready consumer such as a display or control sequencer.

---
 rtl/prio_code_capture.sv | 172 +++++++++++++++++
 tb/tb_prio_code_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prio_code_capture.sv
// Captures debounced press events from an 8-to-3 active-low priority encoder
// into a small FIFO drained by a valid/ready consumer.
module prio_code_capture #(
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 4
) (
    input  logic                     iClk,
    input  logic                     iRst_L,
    input  logic [2:0]               iY_L,
    input  logic                     iYex_L,
    input  logic                     iYs,
    input  logic                     iReady,
    input  logic                     iClrOvf,
    output logic [2:0]               oCode,
    output logic                     oValid,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOvf,
    output logic                     oDisabled,
    output logic                     oBusy
);
    localparam int          PW     = $clog2(DEPTH);
    localparam logic [7:0]  DB     = 8'(DEBOUNCE);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C  = (PW+1)'(1);
    localparam logic [PW-1:0] PONE = PW'(1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    // Debounce counter increment, saturating at DEBOUNCE.
    function automatic logic [7:0] satInc(input logic [7:0] c);
        return (c >= DB) ? DB : c + 8'd1;
    endfunction

    // Two-flop synchronisers, reset to the encoder's idle pattern.
    logic [2:0] yL_p0, yL_p1;
    logic       yexL_p0, yexL_p1, ys_p0, ys_p1;

    always_ff @(posedge iClk) begin
        if (!iRst_L) begin
            yL_p0   <= 3'b111;
            yL_p1   <= 3'b111;
            yexL_p0 <= 1'b1;
            yexL_p1 <= 1'b1;
            ys_p0   <= 1'b0;
            ys_p1   <= 1'b0;
        end else begin
            yL_p0   <= iY_L;
            yL_p1   <= yL_p0;
            yexL_p0 <= iYex_L;
            yexL_p1 <= yexL_p0;
            ys_p0   <= iYs;
            ys_p1   <= ys_p0;
        end
    end

    logic [2:0] sCode;
    logic       disabledNow;
    assign sCode       = ~yL_p1;
    assign disabledNow = yexL_p1 & ys_p1;

    // Debounce FSM
    state_t     state;
    logic [7:0] cnt;
    logic [2:0] cand;
    logic       disReg;
    logic       pushReq;

    assign pushReq = (state == PRESS_DB) && !disabledNow && !yexL_p1 &&
                     (sCode == cand) && (satInc(cnt) == DB);

    always_ff @(posedge iClk) begin
        if (!iRst_L) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            disReg <= 1'b0;
        end else begin
            disReg <= disabledNow;
            if (disabledNow) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!yexL_p1) begin
                            state <= PRESS_DB;
                            cnt   <= 8'd1;
                        end
                    end
                    PRESS_DB: begin
                        if (yexL_p1) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else if (sCode != cand) begin
                            cnt <= 8'd1;
                        end else begin
                            cnt <= satInc(cnt);
                            if (satInc(cnt) == DB) state <= HELD;
                        end
                    end
                    HELD: begin
                        if (yexL_p1) begin
                            state <= REL_DB;
                            cnt   <= 8'd1;
                        end
                    end
                    REL_DB: begin
                        if (!yexL_p1) begin
                            state <= HELD;
                            cnt   <= 8'd0;
                        end else if (satInc(cnt) == DB) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else begin
                            cnt <= satInc(cnt);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

    // Candidate code follows the synchronised code whenever a new press starts or the code changes mid-debounce.
    always_ff @(posedge iClk) begin
        if ((state == IDLE && !yexL_p1) || (state == PRESS_DB && sCode != cand))
            cand <= sCode;
    end

    // Event FIFO
    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0]   count;
    logic          full, pop, doWrite, ovf;

    assign full    = (count == FULL_C);
    assign pop     = (count != '0) && iReady;
    assign doWrite = pushReq && (!full || pop);

    always_ff @(posedge iClk) begin
        if (doWrite) mem[wrPtr] <= cand;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_L) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + PONE;
            if (pop)     rdPtr <= rdPtr + PONE;
            case ({doWrite, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            if (pushReq && full && !pop) ovf <= 1'b1;
            else if (iClrOvf)            ovf <= 1'b0;
        end
    end

    assign oValid    = (count != '0);
    assign oCode     = oValid ? mem[rdPtr] : 3'b000;
    assign oCount    = count;
    assign oOvf      = ovf;
    assign oDisabled = disReg;
    assign oBusy     = (state != IDLE);

endmodule

// File: tb/tb_prio_code_capture.sv
// Directed bench for prio_code_capture: vector table for the basic press
// lifecycle, hand-written sequences for bounce, overflow, disable and reset.
module tb_prio_code_capture;
    logic       iClk = 1'b0;
    logic       iRst_L;
    logic [2:0] iY_L;
    logic       iYex_L, iYs, iReady, iClrOvf;
    logic [2:0] oCode;
    logic       oValid, oOvf, oDisabled, oBusy;
    logic [2:0] oCount;

    int checks = 0;
    int errors = 0;

    prio_code_capture #(.DEBOUNCE(4), .DEPTH(4)) dut (
        .iClk(iClk), .iRst_L(iRst_L), .iY_L(iY_L), .iYex_L(iYex_L), .iYs(iYs),
        .iReady(iReady), .iClrOvf(iClrOvf), .oCode(oCode), .oValid(oValid),
        .oCount(oCount), .oOvf(oOvf), .oDisabled(oDisabled), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [2:0] yL;
        logic       yexL;
        logic       ys;
        logic       rdy;
        logic [7:0] cyc;
        logic [2:0] eCount;
        logic       eValid;
        logic [2:0] eCode;
        logic       eBusy;
        logic       eOvf;
        logic       eDis;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idleIn();
        iY_L   = 3'b111;
        iYex_L = 1'b1;
        iYs    = 1'b0;
    endtask

    // Full press (held holdCyc cycles) followed by a release long enough to reach IDLE.
    task automatic press(input logic [2:0] code, input int holdCyc);
        iY_L   = ~code;
        iYex_L = 1'b0;
        repeat (holdCyc) tick();
        idleIn();
        repeat (10) tick();
    endtask

    // Press from IDLE with iReady/iClrOvf asserted only on the push edge (edge 6); returns just after it.
    task automatic pressEdge(input logic [2:0] code, input logic rdy, input logic clr);
        iY_L   = ~code;
        iYex_L = 1'b0;
        repeat (5) tick();
        iReady  = rdy;
        iClrOvf = clr;
        tick();
        iReady  = 1'b0;
        iClrOvf = 1'b0;
    endtask

    task automatic popOne();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
    endtask

    initial begin
        logic [2:0] drainA[4];
        logic [2:0] drainB[4];

        //             yL      yexL  ys    rdy   cyc    cnt   vld   code  busy  ovf   dis
        tbl[0] = {3'b111, 1'b1, 1'b0, 1'b0, 8'd20,  3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = {3'b000, 1'b0, 1'b0, 1'b0, 8'd2,   3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = {3'b000, 1'b0, 1'b0, 1'b0, 8'd1,   3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[3] = {3'b000, 1'b0, 1'b0, 1'b0, 8'd2,   3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[4] = {3'b000, 1'b0, 1'b0, 1'b0, 8'd1,   3'd1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
        tbl[5] = {3'b000, 1'b0, 1'b0, 1'b0, 8'd100, 3'd1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
        tbl[6] = {3'b111, 1'b1, 1'b0, 1'b0, 8'd5,   3'd1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
        tbl[7] = {3'b111, 1'b1, 1'b0, 1'b0, 8'd1,   3'd1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[8] = {3'b111, 1'b1, 1'b0, 1'b1, 8'd1,   3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[9] = {3'b111, 1'b1, 1'b0, 1'b1, 8'd3,   3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        drainA[0] = 3'd1; drainA[1] = 3'd2; drainA[2] = 3'd3; drainA[3] = 3'd4;
        drainB[0] = 3'd2; drainB[1] = 3'd3; drainB[2] = 3'd4; drainB[3] = 3'd6;

        idleIn();
        iReady  = 1'b0;
        iClrOvf = 1'b0;
        iRst_L  = 1'b0;
        repeat (2) tick();
        check("rst.count", oCount, 0);
        check("rst.valid", oValid, 0);
        check("rst.code", oCode, 0);
        check("rst.busy", oBusy, 0);
        check("rst.ovf", oOvf, 0);
        check("rst.dis", oDisabled, 0);
        iRst_L = 1'b1;

        for (int i = 0; i < 10; i++) begin
            iY_L   = tbl[i].yL;
            iYex_L = tbl[i].yexL;
            iYs    = tbl[i].ys;
            iReady = tbl[i].rdy;
            repeat (int'(tbl[i].cyc)) tick();
            check($sformatf("vec%0d.count", i), oCount, tbl[i].eCount);
            check($sformatf("vec%0d.valid", i), oValid, tbl[i].eValid);
            check($sformatf("vec%0d.code", i), oCode, tbl[i].eCode);
            check($sformatf("vec%0d.busy", i), oBusy, tbl[i].eBusy);
            check($sformatf("vec%0d.ovf", i), oOvf, tbl[i].eOvf);
            check($sformatf("vec%0d.dis", i), oDisabled, tbl[i].eDis);
        end
        iReady = 1'b0;

        // Bounce: request toggles every 2 cycles, never stable long enough.
        iY_L = 3'b101;
        for (int i = 0; i < 20; i++) begin
            iYex_L = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        check("bounce.count", oCount, 0);
        iYex_L = 1'b0;
        repeat (10) tick();
        check("bounce.hold.count", oCount, 1);
        check("bounce.hold.code", oCode, 2);
        repeat (10) tick();
        check("bounce.single", oCount, 1);
        idleIn();
        repeat (10) tick();
        popOne();
        check("bounce.drained", oCount, 0);

        // Overflow: five presses into a 4-deep FIFO.
        for (int k = 1; k <= 4; k++) press(3'(k), 10);
        check("ovf.full.count", oCount, 4);
        check("ovf.notyet", oOvf, 0);
        press(3'd5, 10);
        check("ovf.count", oCount, 4);
        check("ovf.flag", oOvf, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf.drain%0d", k), oCode, drainA[k]);
            popOne();
        end
        check("ovf.empty", oCount, 0);
        check("ovf.sticky", oOvf, 1);
        iClrOvf = 1'b1;
        tick();
        iClrOvf = 1'b0;
        check("ovf.clear", oOvf, 0);

        // Clear coinciding with a new overflow: set wins.
        for (int k = 1; k <= 4; k++) press(3'(k), 10);
        pressEdge(3'd5, 1'b0, 1'b1);
        check("setwins.ovf", oOvf, 1);
        check("setwins.count", oCount, 4);
        iClrOvf = 1'b1;
        tick();
        iClrOvf = 1'b0;
        check("setwins.clear", oOvf, 0);
        idleIn();
        repeat (10) tick();

        // Full with simultaneous pop on the push edge.
        pressEdge(3'd6, 1'b1, 1'b0);
        check("fullpop.count", oCount, 4);
        check("fullpop.ovf", oOvf, 0);
        check("fullpop.head", oCode, 2);
        idleIn();
        repeat (10) tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fullpop.drain%0d", k), oCode, drainB[k]);
            popOne();
        end
        check("fullpop.empty", oValid, 0);

        // Disable while debouncing a press.
        iY_L   = 3'b100;
        iYex_L = 1'b0;
        repeat (2) tick();
        iY_L   = 3'b111;
        iYex_L = 1'b1;
        iYs    = 1'b1;
        tick();
        check("dis.e3.busy", oBusy, 1);
        tick();
        check("dis.e4.dis", oDisabled, 0);
        tick();
        check("dis.e5.busy", oBusy, 0);
        check("dis.e5.dis", oDisabled, 1);
        repeat (10) tick();
        check("dis.count", oCount, 0);
        check("dis.hold", oDisabled, 1);
        iYs = 1'b0;
        repeat (3) tick();
        check("dis.off", oDisabled, 0);

        // Reset while HELD with two entries queued.
        press(3'd4, 10);
        iY_L   = ~3'd5;
        iYex_L = 1'b0;
        repeat (10) tick();
        check("rsth.count", oCount, 2);
        check("rsth.busy", oBusy, 1);
        iRst_L = 1'b0;
        idleIn();
        tick();
        check("rsth.r.count", oCount, 0);
        check("rsth.r.valid", oValid, 0);
        check("rsth.r.busy", oBusy, 0);
        check("rsth.r.code", oCode, 0);
        iRst_L = 1'b1;
        repeat (10) tick();
        check("rsth.after.count", oCount, 0);
        check("rsth.after.busy", oBusy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
